// File: rtl/clk_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// clk_ctrl_pkg
// Shared encodings for the CPU clock divider controller.
//   mode_e       : requested / active clock mode
//   step_state_e : single-step pulse state machine
// ---------------------------------------------------------------------------
package clk_ctrl_pkg;

    typedef enum logic [1:0] {
        MODE_SLOW = 2'b00,
        MODE_FAST = 2'b01,
        MODE_STEP = 2'b10,
        MODE_HALT = 2'b11
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HIGH = 1'b1
    } step_state_e;

endpackage

// File: rtl/clk_divider_ctrl_step_debounce.sv
// ---------------------------------------------------------------------------
// step_debounce
// Debounces the raw single-step push-button.
//   clk_in  : board clock
//   rst     : asynchronous active-low reset
//   btn_raw : raw, bouncing, active-high button
//   press   : one-cycle pulse on each accepted 0->1 transition
// Latency from a clean edge on btn_raw to press is 2 + DEB_CYCLES cycles.
// ---------------------------------------------------------------------------
module step_debounce #(
    parameter int DEB_CYCLES = 250000
) (
    input  logic clk_in,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    logic          btn_meta_r;
    logic          btn_sync_r;
    logic          level_r;
    logic [DW-1:0] cnt_r;
    logic          press_r;

    logic          differs_s;
    logic          accept_s;
    logic [DW-1:0] cnt_s;
    logic          level_s;
    logic          press_s;

    // Count consecutive synchronised samples that disagree with the accepted level.
    always_comb begin
        differs_s = (btn_sync_r != level_r);
        accept_s  = differs_s && (cnt_r == DEB_LAST);
        cnt_s     = '0;
        level_s   = level_r;
        press_s   = 1'b0;
        if (accept_s) begin
            cnt_s   = '0;
            level_s = btn_sync_r;
            press_s = btn_sync_r;
        end else if (differs_s) begin
            cnt_s   = cnt_r + DW'(1);
        end else begin
            // A sample equal to the accepted level restarts the stability window.
            cnt_s   = '0;
        end
    end

    // Synchroniser, stability counter and registered press pulse.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            btn_meta_r <= 1'b0;
            btn_sync_r <= 1'b0;
            level_r    <= 1'b0;
            cnt_r      <= '0;
            press_r    <= 1'b0;
        end else begin
            btn_meta_r <= btn_raw;
            btn_sync_r <= btn_meta_r;
            level_r    <= level_s;
            cnt_r      <= cnt_s;
            press_r    <= press_s;
        end
    end

    assign press = press_r;

endmodule

// File: rtl/clk_divider_ctrl.sv
// ---------------------------------------------------------------------------
// clk_divider_ctrl
// Generates the CPU clock from the board clock with slow/fast run modes,
// debounced single-step and halt. Mode changes only take effect while
// clk_out is low, so no high phase is ever shortened.
//   clk_in      : board clock, all logic on its rising edge
//   rst         : asynchronous active-low reset
//   mode        : requested mode (asynchronous, double-synchronised)
//   step_btn    : raw step push-button
//   clk_out     : divided CPU clock (registered)
//   tick        : one-cycle pulse on the edge clk_out rises
//   edge_cnt    : clk_out rising edges since reset, wrapping
//   active_mode : mode currently in effect
// ---------------------------------------------------------------------------
module clk_divider_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int          CNT_W      = 32,
    parameter int          HALF_FAST  = 31,
    parameter int          HALF_SLOW  = 2500001,
    parameter int          STEP_HIGH  = 4,
    parameter int          DEB_CYCLES = 250000,
    parameter logic [1:0]  RESET_MODE = 2'b00
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] edge_cnt,
    output logic [1:0]       active_mode
);

    localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(HALF_FAST - 1);
    localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(HALF_SLOW - 1);
    localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_HIGH - 1);

    logic [1:0]       mode_meta_r;
    logic [1:0]       mode_sync_r;
    logic [CNT_W-1:0] cnt_r;
    logic             clk_out_r;
    logic             tick_r;
    logic [CNT_W-1:0] edge_cnt_r;
    logic [1:0]       active_mode_r;
    step_state_e      step_state_r;

    logic [CNT_W-1:0] cnt_s;
    logic             clk_out_s;
    logic             rise_s;
    logic [1:0]       active_mode_s;
    step_state_e      step_state_s;
    logic             mode_diff_s;
    logic [CNT_W-1:0] half_last_s;
    logic             press_s;

    step_debounce #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_step_debounce (
        .clk_in  (clk_in),
        .rst     (rst),
        .btn_raw (step_btn),
        .press   (press_s)
    );

    // Next-state for divider counter, clk_out level, step FSM and active mode.
    always_comb begin
        cnt_s         = cnt_r;
        clk_out_s     = clk_out_r;
        rise_s        = 1'b0;
        active_mode_s = active_mode_r;
        step_state_s  = step_state_r;
        mode_diff_s   = (mode_sync_r != active_mode_r);
        half_last_s   = (active_mode_r == MODE_FAST) ? FAST_LAST : SLOW_LAST;

        case (active_mode_r)
            MODE_SLOW, MODE_FAST: begin
                step_state_s = ST_IDLE;
                if (clk_out_r) begin
                    if (cnt_r == half_last_s) begin
                        // Falling edge: the only point a high phase may hand over.
                        clk_out_s = 1'b0;
                        cnt_s     = '0;
                        if (mode_diff_s) begin
                            active_mode_s = mode_sync_r;
                        end else begin
                            active_mode_s = active_mode_r;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else if (cnt_r == half_last_s) begin
                    // End of low half wins over a late switch request; the
                    // switch then waits for the following falling edge.
                    clk_out_s = 1'b1;
                    cnt_s     = '0;
                    rise_s    = 1'b1;
                end else if (mode_diff_s) begin
                    active_mode_s = mode_sync_r;
                    cnt_s         = '0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end

            MODE_STEP: begin
                case (step_state_r)
                    ST_IDLE: begin
                        clk_out_s = 1'b0;
                        cnt_s     = '0;
                        if (mode_diff_s) begin
                            // Leaving step mode discards a coincident press.
                            active_mode_s = mode_sync_r;
                        end else if (press_s) begin
                            step_state_s = ST_HIGH;
                            clk_out_s    = 1'b1;
                            rise_s       = 1'b1;
                        end else begin
                            step_state_s = ST_IDLE;
                        end
                    end
                    ST_HIGH: begin
                        // cnt_r doubles as the high-time counter; presses are ignored here.
                        if (cnt_r == STEP_LAST) begin
                            step_state_s = ST_IDLE;
                            clk_out_s    = 1'b0;
                            cnt_s        = '0;
                            if (mode_diff_s) begin
                                active_mode_s = mode_sync_r;
                            end else begin
                                active_mode_s = active_mode_r;
                            end
                        end else begin
                            cnt_s = cnt_r + CNT_W'(1);
                        end
                    end
                    default: begin
                        step_state_s = ST_IDLE;
                        clk_out_s    = 1'b0;
                        cnt_s        = '0;
                    end
                endcase
            end

            MODE_HALT: begin
                clk_out_s    = 1'b0;
                cnt_s        = '0;
                step_state_s = ST_IDLE;
                if (mode_diff_s) begin
                    active_mode_s = mode_sync_r;
                end else begin
                    active_mode_s = active_mode_r;
                end
            end

            default: begin
                clk_out_s     = 1'b0;
                cnt_s         = '0;
                step_state_s  = ST_IDLE;
                active_mode_s = RESET_MODE;
            end
        endcase
    end

    // Mode synchroniser and all controller state registers.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            mode_meta_r   <= 2'b00;
            mode_sync_r   <= 2'b00;
            cnt_r         <= '0;
            clk_out_r     <= 1'b0;
            tick_r        <= 1'b0;
            edge_cnt_r    <= '0;
            active_mode_r <= RESET_MODE;
            step_state_r  <= ST_IDLE;
        end else begin
            mode_meta_r   <= mode;
            mode_sync_r   <= mode_meta_r;
            cnt_r         <= cnt_s;
            clk_out_r     <= clk_out_s;
            tick_r        <= rise_s;
            edge_cnt_r    <= edge_cnt_r + CNT_W'(rise_s);
            active_mode_r <= active_mode_s;
            step_state_r  <= step_state_s;
        end
    end

    assign clk_out     = clk_out_r;
    assign tick        = tick_r;
    assign edge_cnt    = edge_cnt_r;
    assign active_mode = active_mode_r;

endmodule

// File: tb/tb_clk_divider_ctrl.sv
module tb_clk_divider_ctrl;

    localparam int CW = 4;
    localparam int HF = 3;
    localparam int HS = 5;
    localparam int SH = 2;
    localparam int DB = 4;

    logic          clk_in = 1'b0;
    logic          rst = 1'b0;
    logic [1:0]    mode = 2'b00;
    logic          step_btn = 1'b0;
    logic          clk_out;
    logic          tick;
    logic [CW-1:0] edge_cnt;
    logic [1:0]    active_mode;

    int checks = 0;
    int errors = 0;
    int dut_ticks = 0;

    // reference model state: phase level, cycles spent in phase, active mode
    int m_act = 0, m_clk = 0, m_el = 0, m_ecnt = 0, m_tick = 0;
    int m_s1 = 0, m_s2 = 0;
    int b1 = 0, b2 = 0, lvl = 0, run = 0, press_pend = 0;

    always #5 clk_in = ~clk_in;

    clk_divider_ctrl #(
        .CNT_W      (CW),
        .HALF_FAST  (HF),
        .HALF_SLOW  (HS),
        .STEP_HIGH  (SH),
        .DEB_CYCLES (DB),
        .RESET_MODE (2'b00)
    ) u_dut (
        .clk_in      (clk_in),
        .rst         (rst),
        .mode        (mode),
        .step_btn    (step_btn),
        .clk_out     (clk_out),
        .tick        (tick),
        .edge_cnt    (edge_cnt),
        .active_mode (active_mode)
    );

    function automatic int half_len(input int m);
        return (m == 1) ? HF : HS;
    endfunction

    task automatic model_reset();
        m_act = 0; m_clk = 0; m_el = 0; m_ecnt = 0; m_tick = 0;
        m_s1 = 0; m_s2 = 0; b1 = 0; b2 = 0; lvl = 0; run = 0; press_pend = 0;
    endtask

    // one board-clock edge of the reference behaviour
    task automatic model_edge();
        int sync, pr, diff, rise, phase_len;
        if (!rst) begin
            model_reset();
        end else begin
            sync = m_s2;
            pr   = press_pend;
            diff = (sync != m_act) ? 1 : 0;
            rise = 0;
            if (m_act <= 1) begin
                phase_len = half_len(m_act);
                if (m_clk == 1) begin
                    if (m_el + 1 == phase_len) begin
                        m_clk = 0; m_el = 0;
                        if (diff != 0) m_act = sync;
                    end else m_el++;
                end else if (m_el + 1 == phase_len) begin
                    m_clk = 1; m_el = 0; rise = 1;
                end else if (diff != 0) begin
                    m_act = sync; m_el = 0;
                end else m_el++;
            end else if (m_act == 2) begin
                if (m_clk == 1) begin
                    if (m_el + 1 == SH) begin
                        m_clk = 0; m_el = 0;
                        if (diff != 0) m_act = sync;
                    end else m_el++;
                end else if (diff != 0) begin
                    m_act = sync; m_el = 0;
                end else if (pr != 0) begin
                    m_clk = 1; m_el = 0; rise = 1;
                end
            end else begin
                if (diff != 0) m_act = sync;
            end
            m_tick = rise;
            if (rise != 0) m_ecnt = (m_ecnt + 1) % (1 << CW);
            // debounced button: level accepted after DB equal samples
            press_pend = 0;
            if (b2 != lvl) begin
                run++;
                if (run == DB) begin
                    lvl = b2; press_pend = b2; run = 0;
                end
            end else run = 0;
            m_s2 = m_s1; m_s1 = int'(mode);
            b2 = b1; b1 = int'(step_btn);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        chk("clk_out", int'(clk_out), m_clk);
        chk("tick", int'(tick), m_tick);
        chk("edge_cnt", int'(edge_cnt), m_ecnt);
        chk("active_mode", int'(active_mode), m_act);
    endtask

    // advance n cycles, checking the DUT against the model after every edge
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk_in);
            model_edge();
            #1;
            compare();
            dut_ticks += int'(tick);
            @(negedge clk_in);
        end
    endtask

    task automatic wait_tick(input string name, input int limit);
        int k;
        k = 0;
        cyc(1);
        while (tick !== 1'b1 && k < limit) begin
            cyc(1);
            k++;
        end
        if (tick !== 1'b1) chk({name, "_timeout"}, 0, 1);
    endtask

    initial begin
        int t0, k, hold;

        // 1: reset and slow run
        cyc(3);
        chk("rst_clk_out", int'(clk_out), 0);
        chk("rst_edge_cnt", int'(edge_cnt), 0);
        chk("rst_active", int'(active_mode), 0);
        rst = 1'b1;
        cyc(25);
        chk("slow_third_tick", int'(tick), 1);
        chk("slow_edge_cnt3", int'(edge_cnt), 3);
        cyc(1);
        chk("slow_high_hold", int'(clk_out), 1);
        chk("slow_tick_once", int'(tick), 0);

        // 2: slow -> fast requested inside a high phase
        mode = 2'b01;
        cyc(3);
        chk("sw_high_kept", int'(clk_out), 1);
        chk("sw_active_old", int'(active_mode), 0);
        cyc(1);
        chk("sw_fall", int'(clk_out), 0);
        chk("sw_active_new", int'(active_mode), 1);
        cyc(3);
        chk("fast_rise", int'(tick), 1);
        cyc(3);
        chk("fast_fall", int'(clk_out), 0);
        cyc(3);
        chk("fast_rise2", int'(tick), 1);

        // 3: single-step with a bouncing button
        mode = 2'b10;
        cyc(3);
        chk("step_entered", int'(active_mode), 2);
        chk("step_idle_low", int'(clk_out), 0);
        t0 = dut_ticks;
        for (int i = 0; i < 5; i++) begin
            step_btn = ((i % 2) == 1) ? 1'b1 : 1'b0;
            cyc(2);
        end
        chk("bounce_no_press", dut_ticks - t0, 0);
        step_btn = 1'b1;
        cyc(6);
        chk("step_pre_rise", int'(clk_out), 0);
        cyc(1);
        chk("step_rise", int'(clk_out), 1);
        chk("step_tick", int'(tick), 1);
        cyc(1);
        chk("step_high2", int'(clk_out), 1);
        cyc(1);
        chk("step_fall", int'(clk_out), 0);
        chk("step_one_tick", dut_ticks - t0, 1);
        step_btn = 1'b0;
        cyc(8);
        step_btn = 1'b1;
        cyc(10);
        chk("step_second_press", dut_ticks - t0, 2);

        // 4: halt entered in a low phase, then back to fast
        mode = 2'b01;
        wait_tick("fast_restart", 40);
        cyc(1);
        mode = 2'b11;
        cyc(3);
        chk("halt_active", int'(active_mode), 3);
        chk("halt_low", int'(clk_out), 0);
        t0 = dut_ticks;
        cyc(50);
        chk("halt_no_ticks", dut_ticks - t0, 0);
        mode = 2'b01;
        cyc(3);
        chk("unhalt_active", int'(active_mode), 1);
        cyc(2);
        chk("unhalt_low", int'(clk_out), 0);
        cyc(1);
        chk("unhalt_rise", int'(tick), 1);

        // 5: edge counter wrap
        k = 0;
        while (edge_cnt != 4'd15 && k < 200) begin
            cyc(1);
            k++;
        end
        chk("reach_15", int'(edge_cnt), 15);
        wait_tick("wrap_tick", 20);
        chk("wrap_zero", int'(edge_cnt), 0);
        t0 = dut_ticks;
        cyc(96);
        chk("sixteen_ticks", dut_ticks - t0, 16);
        chk("wrap_again", int'(edge_cnt), 0);

        // 6: asynchronous reset in the middle of a step high phase
        mode = 2'b10;
        k = 0;
        while (active_mode != 2'b10 && k < 40) begin
            cyc(1);
            k++;
        end
        chk("step_again", int'(active_mode), 2);
        step_btn = 1'b0;
        cyc(6);
        step_btn = 1'b1;
        cyc(7);
        chk("pre_rst_high", int'(clk_out), 1);
        @(posedge clk_in);
        model_edge();
        #1;
        compare();
        #2;
        rst = 1'b0;
        #1;
        chk("async_clk_out", int'(clk_out), 0);
        chk("async_tick", int'(tick), 0);
        chk("async_edge_cnt", int'(edge_cnt), 0);
        @(negedge clk_in);
        cyc(2);
        rst = 1'b1;
        cyc(1);
        chk("post_rst_active", int'(active_mode), 0);

        // randomized traffic
        hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 63) == 0) mode = 2'($urandom_range(0, 3));
            if (hold == 0) begin
                step_btn = ~step_btn;
                hold = $urandom_range(1, 10);
            end else begin
                hold--;
            end
            if ($urandom_range(0, 1499) == 0) begin
                rst = 1'b0;
                cyc(2);
                rst = 1'b1;
            end
            cyc(1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
